cache_fill_ctrl: RTL

- Parametrised cache-line fill controller; next generation of the single-line miss-fill FSM.
- Sits between the cache tag-match logic and the memory request/return bus.
- On a miss it latches the line address and victim way, then issues one word request per cycle.
- It writes returning beats into the data array (one-hot word select) and commits the tag once the line is complete.
- Generalised in address width, word size, line length and way count; adds a latched miss address, explicit victim-way capture and separate issue/return counters.

---
 rtl/cache_fill_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// Cache-line miss-fill controller: latches miss line/way, streams word requests, commits tag.
// Optional critical-word-first ordering via `define CRITICAL_WORD_FIRST_EN.
module cache_fill_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int WORD_BYTES     = 2,
  parameter int WORDS_PER_LINE = 8,
  parameter int NUM_WAYS       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss_detected,
  input  logic [ADDR_W-1:0]         miss_address,
  input  logic [NUM_WAYS-1:0]       victim_way,
  input  logic                      memory_data_valid,
  output logic                      fsm_busy,
  output logic                      mem_req_valid,
  output logic [ADDR_W-1:0]         memory_address,
  output logic                      write_data_array,
  output logic [WORDS_PER_LINE-1:0] word_sel,
  output logic                      write_tag_array,
  output logic [NUM_WAYS-1:0]       fill_way,
  output logic                      fill_done,
  output logic                      crit_word_ready
);

  localparam int BYTE_W = $clog2(WORD_BYTES);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int CNT_W  = OFF_W + 1;

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << (OFF_W + BYTE_W)) - ADDR_W'(1));
  localparam logic [CNT_W-1:0] WPL_C  = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    issue_q, issue_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [OFF_W-1:0]    start_q, start_d;
  logic [NUM_WAYS-1:0] way_q, way_d;
  logic [OFF_W-1:0]    req_off;
  logic [OFF_W-1:0]    ret_off;
  logic [OFF_W-1:0]    miss_off;

  // Offsets wrap inside the line; the base keeps only the line-aligned bits.
  assign req_off = start_q + issue_q[OFF_W-1:0];
  assign ret_off = start_q + ret_q[OFF_W-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
  assign miss_off = miss_address[OFF_W+BYTE_W-1:BYTE_W];
`else
  assign miss_off = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      issue_q <= '0;
      ret_q   <= '0;
      base_q  <= '0;
      start_q <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      base_q  <= base_d;
      start_q <= start_d;
      way_q   <= way_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    issue_d          = issue_q;
    ret_d            = ret_q;
    base_d           = base_q;
    start_d          = start_q;
    way_d            = way_q;
    fsm_busy         = 1'b0;
    mem_req_valid    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_sel         = '0;
    write_tag_array  = 1'b0;
    fill_way         = '0;
    fill_done        = 1'b0;
    crit_word_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          state_d = FILL;
          issue_d = '0;
          ret_d   = '0;
          base_d  = miss_address & LINE_MASK;
          start_d = miss_off;
          way_d   = victim_way;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        fill_way = way_q;
        if (issue_q < WPL_C) begin
          mem_req_valid  = 1'b1;
          memory_address = base_q | (ADDR_W'(req_off) << BYTE_W);
          issue_d        = issue_q + CNT_W'(1);
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_sel         = WORDS_PER_LINE'(1) << ret_off;
          ret_d            = ret_q + CNT_W'(1);
`ifdef CRITICAL_WORD_FIRST_EN
          crit_word_ready  = (ret_q == '0);
`endif
          if (ret_q == LAST_C) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        fsm_busy        = 1'b1;
        fill_way        = way_q;
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset wins combinationally too: nothing is written in the reset cycle.
    if (rst) begin
      fsm_busy         = 1'b0;
      mem_req_valid    = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      word_sel         = '0;
      write_tag_array  = 1'b0;
      fill_way         = '0;
      fill_done        = 1'b0;
      crit_word_ready  = 1'b0;
    end
  end

endmodule
